// File: rtl/pipearch_common.sv
// Shared definitions for the DMA read arbiter: mdata field widths,
// arbiter FSM state type and mdata pack/unpack helpers.
package pipearch_common;

    localparam int ENGINE_ID_W = 4;
    localparam int MDATA_SEQ_W = 12;

    typedef enum logic [1:0] {
        RUN,
        DRAIN,
        DRAINED
    } t_rd_arb_state;

    function automatic logic [15:0] mdata_pack(
        input logic [MDATA_SEQ_W-1:0] seq,
        input logic [ENGINE_ID_W-1:0] id
    );
        return {seq, id};
    endfunction

    function automatic logic [ENGINE_ID_W-1:0] mdata_engine(
        input logic [15:0] mdata
    );
        return mdata[ENGINE_ID_W-1:0];
    endfunction

endpackage

// File: rtl/pipearch_dma_read_arbiter_if.sv
// Engine-side and c0-side signal bundle of the DMA read arbiter.
// master: arbiter view; slave: environment (engines + c0 channel) view.
interface pipearch_dma_read_arbiter_if #(
    parameter int NUM_ENGINES = 4,
    parameter int ADDR_W      = 42,
    parameter int DATA_W      = 512
);
    logic                          c0TxAlmFull;
    logic [1:0]                    vc_select;
    logic [NUM_ENGINES-1:0]        req_valid;
    logic [NUM_ENGINES*ADDR_W-1:0] req_addr;
    logic [NUM_ENGINES-1:0]        req_ready;
    logic                          tx_valid;
    logic [ADDR_W-1:0]             tx_addr;
    logic [1:0]                    tx_vc;
    logic [15:0]                   tx_mdata;
    logic                          rx_valid;
    logic [15:0]                   rx_mdata;
    logic [DATA_W-1:0]             rx_data;
    logic [NUM_ENGINES-1:0]        rsp_valid;
    logic [DATA_W-1:0]             rsp_data;
    logic                          drain_req;
    logic                          drain_done;
    logic [1:0]                    err_sticky;

    modport master (
        input  c0TxAlmFull, vc_select, req_valid, req_addr,
        input  rx_valid, rx_mdata, rx_data, drain_req,
        output req_ready, tx_valid, tx_addr, tx_vc, tx_mdata,
        output rsp_valid, rsp_data, drain_done, err_sticky
    );

    modport slave (
        output c0TxAlmFull, vc_select, req_valid, req_addr,
        output rx_valid, rx_mdata, rx_data, drain_req,
        input  req_ready, tx_valid, tx_addr, tx_vc, tx_mdata,
        input  rsp_valid, rsp_data, drain_done, err_sticky
    );
endinterface

// File: rtl/pipearch_rr_arbiter.sv
// Combinational round-robin picker: first eligible requester at or
// after ptr_i (wrapping). Ports: eligible_i, ptr_i -> grant_o, idx_o, any_o.
module pipearch_rr_arbiter #(
    parameter int N = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  eligible_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  grant_o,
    output logic [IW-1:0] idx_o,
    output logic          any_o
);
    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        any_o   = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!any_o && eligible_i[(int'(ptr_i) + k) % N]) begin
                any_o = 1'b1;
                grant_o[(int'(ptr_i) + k) % N] = 1'b1;
                idx_o = IW'((int'(ptr_i) + k) % N);
            end
        end
    end
endmodule

// File: rtl/pipearch_dma_read_arbiter.sv
// N-engine CCI-P c0 read front end: RR arbitration with per-engine
// credits, engine ID in mdata, response routing and drain handshake.
// Ports: clk, reset (sync, active-high), bus (master modport).
module pipearch_dma_read_arbiter
    import pipearch_common::*;
#(
    parameter int NUM_ENGINES     = 4,
    parameter int MAX_OUTSTANDING = 64,
    parameter int ADDR_W          = 42,
    parameter int DATA_W          = 512
) (
    input logic clk,
    input logic reset,
    pipearch_dma_read_arbiter_if.master bus
);
    localparam int IW = (NUM_ENGINES > 1) ? $clog2(NUM_ENGINES) : 1;
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTSTANDING);

    t_rd_arb_state              state_q, state_d;
    logic [CW-1:0]              cnt_q [NUM_ENGINES];
    logic [CW-1:0]              cnt_d [NUM_ENGINES];
    logic [IW-1:0]              rr_q, rr_d;
    logic [MDATA_SEQ_W-1:0]     seq_q, seq_d;
    logic                       tx_valid_q;
    logic [ADDR_W-1:0]          tx_addr_q, tx_addr_d;
    logic [1:0]                 tx_vc_q, tx_vc_d;
    logic [15:0]                tx_mdata_q, tx_mdata_d;
    logic [NUM_ENGINES-1:0]     rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]          rsp_data_q, rsp_data_d;
    logic [1:0]                 err_q, err_d;

    logic [NUM_ENGINES-1:0]     eligible;
    logic [NUM_ENGINES-1:0]     grant;
    logic [IW-1:0]              gnt_idx;
    logic                       accept;
    logic [ENGINE_ID_W-1:0]     rx_id;
    logic                       rx_known;
    logic [NUM_ENGINES-1:0]     rx_hit;
    logic                       zero_hit;
    logic                       all_zero;

    always_comb begin
        eligible = '0;
        for (int e = 0; e < NUM_ENGINES; e++) begin
            eligible[e] = !reset && bus.req_valid[e] && (cnt_q[e] < MAX_CNT)
                          && !bus.c0TxAlmFull && (state_q == RUN);
        end
    end

    pipearch_rr_arbiter #(.N(NUM_ENGINES)) u_rr (
        .eligible_i (eligible),
        .ptr_i      (rr_q),
        .grant_o    (grant),
        .idx_o      (gnt_idx),
        .any_o      (accept)
    );

    assign rx_id    = mdata_engine(bus.rx_mdata);
    assign rx_known = int'(rx_id) < NUM_ENGINES;

    always_comb begin
        rx_hit   = '0;
        zero_hit = 1'b0;
        all_zero = 1'b1;
        for (int e = 0; e < NUM_ENGINES; e++) begin
            rx_hit[e] = bus.rx_valid && rx_known && (int'(rx_id) == e);
            if (rx_hit[e] && cnt_q[e] == '0) zero_hit = 1'b1;
            if (cnt_q[e] != '0) all_zero = 1'b0;
        end
    end

    // Credits: a response against an empty counter is delivered but not
    // debited, so a stale response can never underflow the count.
    always_comb begin
        for (int e = 0; e < NUM_ENGINES; e++) begin
            cnt_d[e] = cnt_q[e];
            if (grant[e] && !(rx_hit[e] && cnt_q[e] != '0)) begin
                cnt_d[e] = cnt_q[e] + 1'b1;
            end else if (!grant[e] && rx_hit[e] && cnt_q[e] != '0) begin
                cnt_d[e] = cnt_q[e] - 1'b1;
            end
        end
    end

    always_comb begin
        err_d = err_q;
        if (bus.rx_valid && !rx_known) err_d[0] = 1'b1;
        if (zero_hit) err_d[1] = 1'b1;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUN:     if (bus.drain_req) state_d = DRAIN;
            DRAIN: begin
                if (!bus.drain_req) state_d = RUN;
                else if (all_zero)  state_d = DRAINED;
            end
            DRAINED: if (!bus.drain_req) state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        rr_d       = rr_q;
        seq_d      = seq_q;
        tx_addr_d  = tx_addr_q;
        tx_vc_d    = tx_vc_q;
        tx_mdata_d = tx_mdata_q;
        if (accept) begin
            rr_d = (int'(gnt_idx) == NUM_ENGINES - 1) ? '0 : gnt_idx + 1'b1;
            seq_d      = seq_q + 1'b1;
            tx_addr_d  = bus.req_addr[int'(gnt_idx)*ADDR_W +: ADDR_W];
            tx_vc_d    = bus.vc_select;
            tx_mdata_d = mdata_pack(seq_q, ENGINE_ID_W'(gnt_idx));
        end
        rsp_valid_d = rx_hit;
        rsp_data_d  = bus.rx_valid ? bus.rx_data : rsp_data_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= RUN;
            rr_q        <= '0;
            seq_q       <= '0;
            tx_valid_q  <= 1'b0;
            tx_addr_q   <= '0;
            tx_vc_q     <= '0;
            tx_mdata_q  <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            err_q       <= '0;
            for (int e = 0; e < NUM_ENGINES; e++) cnt_q[e] <= '0;
        end else begin
            state_q     <= state_d;
            rr_q        <= rr_d;
            seq_q       <= seq_d;
            tx_valid_q  <= accept;
            tx_addr_q   <= tx_addr_d;
            tx_vc_q     <= tx_vc_d;
            tx_mdata_q  <= tx_mdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            err_q       <= err_d;
            for (int e = 0; e < NUM_ENGINES; e++) cnt_q[e] <= cnt_d[e];
        end
    end

    assign bus.req_ready  = grant;
    assign bus.tx_valid   = tx_valid_q;
    assign bus.tx_addr    = tx_addr_q;
    assign bus.tx_vc      = tx_vc_q;
    assign bus.tx_mdata   = tx_mdata_q;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_data   = rsp_data_q;
    assign bus.drain_done = (state_q == DRAINED);
    assign bus.err_sticky = err_q;

endmodule

// File: tb/tb_pipearch_dma_read_arbiter.sv
// Directed bench for pipearch_dma_read_arbiter (4 engines, 2 credits).
// Inputs change on the falling edge; outputs are checked there too.
module tb_pipearch_dma_read_arbiter;
    localparam int NE = 4;
    localparam int AW = 42;
    localparam int DW = 512;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    pipearch_dma_read_arbiter_if #(.NUM_ENGINES(NE), .ADDR_W(AW), .DATA_W(DW)) bus ();

    pipearch_dma_read_arbiter #(
        .NUM_ENGINES(NE), .MAX_OUTSTANDING(2), .ADDR_W(AW), .DATA_W(DW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic rx(input logic [15:0] m, input logic [63:0] d);
        bus.rx_valid = 1'b1;
        bus.rx_mdata = m;
        bus.rx_data  = {8{d}};
    endtask

    initial begin
        bus.c0TxAlmFull = 1'b0;
        bus.vc_select   = 2'b10;
        bus.req_valid   = '0;
        for (int e = 0; e < NE; e++) bus.req_addr[e*AW +: AW] = AW'(64'h100 + e);
        bus.rx_valid  = 1'b0;
        bus.rx_mdata  = '0;
        bus.rx_data   = '0;
        bus.drain_req = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_tx_valid", 64'(bus.tx_valid), 64'd0);
        chk("rst_tx_mdata", 64'(bus.tx_mdata), 64'd0);
        chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        chk("rst_drain_done", 64'(bus.drain_done), 64'd0);
        chk("rst_err", 64'(bus.err_sticky), 64'd0);
        reset = 1'b0;

        // round robin, all engines requesting
        bus.req_valid = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            #1;
            chk($sformatf("rr_ready%0d", i), 64'(bus.req_ready), 64'(1 << (i % 4)));
            @(negedge clk);
            chk($sformatf("rr_txv%0d", i), 64'(bus.tx_valid), 64'd1);
            chk($sformatf("rr_mdata%0d", i), 64'(bus.tx_mdata), 64'((i << 4) | (i % 4)));
            chk($sformatf("rr_addr%0d", i), 64'(bus.tx_addr), 64'(32'h100 + i % 4));
        end
        chk("tx_vc", 64'(bus.tx_vc), 64'd2);
        #1;
        chk("credits_full", 64'(bus.req_ready), 64'd0);
        bus.req_valid = '0;
        @(negedge clk);
        chk("tx_idle", 64'(bus.tx_valid), 64'd0);

        // out-of-order responses
        rx(16'h0023, 64'hAAAA_0003);
        @(negedge clk);
        chk("ooo_rsp3", 64'(bus.rsp_valid), 64'b1000);
        chk("ooo_dat3", bus.rsp_data[63:0], 64'hAAAA_0003);
        rx(16'h0010, 64'hBBBB_0000);
        @(negedge clk);
        chk("ooo_rsp0", 64'(bus.rsp_valid), 64'b0001);
        chk("ooo_dat0", bus.rsp_data[63:0], 64'hBBBB_0000);
        rx(16'h0032, 64'hCCCC_0002);
        @(negedge clk);
        chk("ooo_rsp2", 64'(bus.rsp_valid), 64'b0100);
        chk("ooo_dat2", bus.rsp_data[63:0], 64'hCCCC_0002);
        bus.rx_valid = 1'b0;
        @(negedge clk);
        chk("ooo_idle", 64'(bus.rsp_valid), 64'd0);

        // engine 1 credit-limited, freed by one response
        bus.req_valid = 4'b0010;
        rx(16'h0001, 64'hD1);
        #1;
        chk("e1_blocked", 64'(bus.req_ready), 64'd0);
        @(negedge clk);
        chk("e1_rsp", 64'(bus.rsp_valid), 64'b0010);
        chk("e1_freed", 64'(bus.req_ready), 64'b0010);
        bus.rx_valid = 1'b0;
        @(negedge clk);
        chk("e1_mdata", 64'(bus.tx_mdata), 64'h0081);
        #1;
        chk("e1_full", 64'(bus.req_ready), 64'd0);

        // grant and response to engine 2 in one cycle
        bus.req_valid = 4'b0100;
        rx(16'h00A2, 64'hE2);
        #1;
        chk("same_ready", 64'(bus.req_ready), 64'b0100);
        @(negedge clk);
        chk("same_mdata", 64'(bus.tx_mdata), 64'h0092);
        chk("same_rsp", 64'(bus.rsp_valid), 64'b0100);
        bus.rx_valid = 1'b0;
        #1;
        chk("same_cnt1", 64'(bus.req_ready), 64'b0100);
        @(negedge clk);
        chk("same_mdata2", 64'(bus.tx_mdata), 64'h00A2);
        #1;
        chk("same_cnt2", 64'(bus.req_ready), 64'd0);
        bus.req_valid = '0;

        // unknown engine ID
        rx(16'h000F, 64'hFF);
        @(negedge clk);
        chk("bad_id_rsp", 64'(bus.rsp_valid), 64'd0);
        chk("bad_id_err", 64'(bus.err_sticky), 64'b01);

        // drain with 5 in flight
        rx(16'h0003, 64'h33);
        bus.drain_req = 1'b1;
        @(negedge clk);
        bus.rx_valid = 1'b0;
        bus.req_valid = 4'b1111;
        #1;
        chk("drain_nogrant", 64'(bus.req_ready), 64'd0);
        for (int i = 0; i < 5; i++) begin
            rx(16'((i + 1) / 2), 64'(i));
            @(negedge clk);
            chk($sformatf("drain_wait%0d", i), 64'(bus.drain_done), 64'd0);
            chk($sformatf("drain_ready%0d", i), 64'(bus.req_ready), 64'd0);
        end
        bus.rx_valid = 1'b0;
        @(negedge clk);
        chk("drained", 64'(bus.drain_done), 64'd1);
        bus.drain_req = 1'b0;
        #1;
        chk("drained_nogrant", 64'(bus.req_ready), 64'd0);
        @(negedge clk);
        chk("resume_done", 64'(bus.drain_done), 64'd0);
        #1;
        chk("resume_ready", 64'(bus.req_ready), 64'b1000);
        @(negedge clk);
        bus.req_valid = '0;
        chk("resume_mdata", 64'(bus.tx_mdata), 64'h00B3);

        // almost-full: in-flight accept still emitted, then nothing
        bus.req_valid = 4'b0001;
        #1;
        chk("af_ready", 64'(bus.req_ready), 64'b0001);
        @(negedge clk);
        bus.c0TxAlmFull = 1'b1;
        bus.req_valid = 4'b1111;
        #1;
        chk("af_stop", 64'(bus.req_ready), 64'd0);
        chk("af_last_tx", 64'(bus.tx_valid), 64'd1);
        chk("af_last_md", 64'(bus.tx_mdata), 64'h00C0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk($sformatf("af_tx%0d", i), 64'(bus.tx_valid), 64'd0);
        end
        bus.c0TxAlmFull = 1'b0;
        bus.req_valid = '0;

        // reset mid-flight, then a late response
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rst2_err", 64'(bus.err_sticky), 64'd0);
        chk("rst2_tx", 64'(bus.tx_valid), 64'd0);
        rx(16'h0000, 64'h77);
        @(negedge clk);
        bus.rx_valid = 1'b0;
        chk("late_rsp", 64'(bus.rsp_valid), 64'b0001);
        chk("late_err", 64'(bus.err_sticky), 64'b10);
        bus.drain_req = 1'b1;
        repeat (2) @(negedge clk);
        chk("late_cnt_zero", 64'(bus.drain_done), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
